// File: rtl/tia_audio_pkg.sv
// Shared types, LFSR constants, register offsets and AUDC decode for the TIA-style audio generator.
package tia_audio_pkg;

   typedef enum logic [3:0] {
      ONE        = 4'd0,
      POLY4      = 4'd1,
      POLY4_D31  = 4'd2,
      POLY5      = 4'd3,
      TONE       = 4'd4,
      D31        = 4'd5,
      POLY9      = 4'd6,
      TONE_DIV3  = 4'd7,
      D31_DIV3   = 4'd8,
      POLY5_DIV3 = 4'd9
   } audc_mode_e;

   localparam logic [3:0] P4_SEED = 4'hF;
   localparam logic [4:0] P5_SEED = 5'h1F;
   localparam logic [8:0] P9_SEED = 9'h1FF;

   localparam int P4_TAP_HI = 3;
   localparam int P4_TAP_LO = 2;
   localparam int P5_TAP_HI = 4;
   localparam int P5_TAP_LO = 2;
   localparam int P9_TAP_HI = 8;
   localparam int P9_TAP_LO = 4;

   localparam logic [4:0] D31_LAST  = 5'd30;
   localparam logic [4:0] D31_LIMIT = 5'd13;
   localparam logic [1:0] DIV3_LAST = 2'd2;

   // Register bank offsets, in units of NUM_CH from BASE_ADDR
   localparam int OFF_C = 0;
   localparam int OFF_F = 1;
   localparam int OFF_V = 2;

   function automatic audc_mode_e decode_audc(input logic [3:0] audc);
      audc_mode_e mode;
      case (audc)
         4'h0, 4'hB:        mode = ONE;
         4'h1:              mode = POLY4;
         4'h2:              mode = POLY4_D31;
         4'h3, 4'h7, 4'h9:  mode = POLY5;
         4'h4, 4'h5:        mode = TONE;
         4'h6, 4'hA:        mode = D31;
         4'h8:              mode = POLY9;
         4'hC, 4'hD:        mode = TONE_DIV3;
         4'hE:              mode = D31_DIV3;
         4'hF:              mode = POLY5_DIV3;
         default:           mode = ONE;
      endcase
      return mode;
   endfunction

endpackage

// File: rtl/tia_audio_chan.sv
// One audio channel: AUDC/AUDF/AUDV registers, tick divider, poly4/5/9 LFSRs, d31/div3 counters,
// waveform bit and volume-scaled sample.
module tia_audio_chan
   import tia_audio_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int VOL_W  = 4,
   parameter int FREQ_W = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              tick,
   input  logic              wr_c,
   input  logic              wr_f,
   input  logic              wr_v,
   input  logic [DATA_W-1:0] wdata,
   output logic              aud_bit,
   output logic [VOL_W-1:0]  aud_vol
);

   logic [3:0]        audc_r;
   logic [FREQ_W-1:0] audf_r;
   logic [VOL_W-1:0]  audv_r;
   logic [FREQ_W-1:0] cnt_r;
   logic [3:0]        poly4_r;
   logic [4:0]        poly5_r;
   logic [8:0]        poly9_r;
   logic [4:0]        d31_r;
   logic [1:0]        div3_r;
   logic              aud_bit_r;
   logic [VOL_W-1:0]  aud_vol_r;

   audc_mode_e        mode_s;
   logic              event_s;
   logic              d31_wrap_s;
   logic              div3_wrap_s;
   logic [3:0]        poly4_next_s;
   logic [4:0]        poly5_next_s;
   logic [8:0]        poly9_next_s;
   logic [4:0]        d31_next_s;
   logic [1:0]        div3_next_s;
   logic              bit_next_s;
   logic              unused_wdata_s;

   assign unused_wdata_s = ^wdata;

   // Post-event state of the LFSRs and counters, and the waveform bit they select
   always_comb begin
      mode_s       = decode_audc(audc_r);
      event_s      = tick && (cnt_r >= audf_r);
      d31_wrap_s   = (d31_r == D31_LAST);
      div3_wrap_s  = (div3_r == DIV3_LAST);
      poly4_next_s = {poly4_r[2:0], poly4_r[P4_TAP_HI] ^ poly4_r[P4_TAP_LO]};
      poly5_next_s = {poly5_r[3:0], poly5_r[P5_TAP_HI] ^ poly5_r[P5_TAP_LO]};
      poly9_next_s = {poly9_r[7:0], poly9_r[P9_TAP_HI] ^ poly9_r[P9_TAP_LO]};
      div3_next_s  = div3_wrap_s ? 2'd0 : (div3_r + 2'd1);
      if ((mode_s == D31_DIV3) && !div3_wrap_s) begin
         d31_next_s = d31_r;
      end else begin
         d31_next_s = d31_wrap_s ? 5'd0 : (d31_r + 5'd1);
      end
      case (mode_s)
         ONE:        bit_next_s = 1'b1;
         POLY4:      bit_next_s = poly4_next_s[0];
         POLY4_D31:  bit_next_s = d31_wrap_s ? poly4_next_s[0] : aud_bit_r;
         POLY5:      bit_next_s = poly5_next_s[0];
         TONE:       bit_next_s = ~aud_bit_r;
         D31:        bit_next_s = (d31_next_s < D31_LIMIT);
         POLY9:      bit_next_s = poly9_next_s[0];
         TONE_DIV3:  bit_next_s = div3_wrap_s ? ~aud_bit_r : aud_bit_r;
         D31_DIV3:   bit_next_s = (d31_next_s < D31_LIMIT);
         POLY5_DIV3: bit_next_s = div3_wrap_s ? poly5_next_s[0] : aud_bit_r;
         default:    bit_next_s = 1'b1;
      endcase
   end

   // Register writes, divider, event-driven state advance and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         audc_r    <= 4'd0;
         audf_r    <= {FREQ_W{1'b0}};
         audv_r    <= {VOL_W{1'b0}};
         cnt_r     <= {FREQ_W{1'b0}};
         poly4_r   <= P4_SEED;
         poly5_r   <= P5_SEED;
         poly9_r   <= P9_SEED;
         d31_r     <= 5'd0;
         div3_r    <= 2'd0;
         aud_bit_r <= 1'b0;
         aud_vol_r <= {VOL_W{1'b0}};
      end else begin
         if (wr_c) audc_r <= wdata[3:0];
         if (wr_f) audf_r <= wdata[FREQ_W-1:0];
         if (wr_v) audv_r <= wdata[VOL_W-1:0];
         if (tick) begin
            cnt_r <= event_s ? {FREQ_W{1'b0}} : (cnt_r + FREQ_W'(1));
         end
         if (event_s) begin
            poly4_r   <= poly4_next_s;
            poly5_r   <= poly5_next_s;
            poly9_r   <= poly9_next_s;
            d31_r     <= d31_next_s;
            div3_r    <= div3_next_s;
            aud_bit_r <= bit_next_s;
         end
         aud_vol_r <= aud_bit_r ? audv_r : {VOL_W{1'b0}};
      end
   end

   assign aud_bit = aud_bit_r;
   assign aud_vol = aud_vol_r;

endmodule

// File: rtl/tia_audio_gen.sv
// TIA-style audio generator top: register address decode, NUM_CH channels and optional mixer.
// Macro TIA_AUDIO_MIX_EN builds the registered sum on mix_out; otherwise mix_out is tied to 0.
module tia_audio_gen
   import tia_audio_pkg::*;
#(
   parameter int                NUM_CH    = 2,
   parameter int                ADDR_W    = 6,
   parameter int                DATA_W    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 6'h15,
   parameter int                VOL_W     = 4,
   parameter int                FREQ_W    = 5
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic [ADDR_W-1:0]                    addr,
   input  logic [DATA_W-1:0]                    data,
   input  logic                                 we,
   input  logic                                 tick_30k,
   output logic [NUM_CH-1:0]                    aud_bit,
   output logic [NUM_CH*VOL_W-1:0]              aud_vol,
   output logic [VOL_W+$clog2(NUM_CH+1)-1:0]    mix_out
);

   localparam int MIX_W = VOL_W + $clog2(NUM_CH + 1);

   genvar n;
   generate
      for (n = 0; n < NUM_CH; n++) begin : g_ch
         localparam logic [ADDR_W-1:0] A_C = ADDR_W'(int'(BASE_ADDR) + OFF_C * NUM_CH + n);
         localparam logic [ADDR_W-1:0] A_F = ADDR_W'(int'(BASE_ADDR) + OFF_F * NUM_CH + n);
         localparam logic [ADDR_W-1:0] A_V = ADDR_W'(int'(BASE_ADDR) + OFF_V * NUM_CH + n);

         logic wr_c_s;
         logic wr_f_s;
         logic wr_v_s;

         assign wr_c_s = we && (addr == A_C);
         assign wr_f_s = we && (addr == A_F);
         assign wr_v_s = we && (addr == A_V);

         tia_audio_chan #(
            .DATA_W (DATA_W),
            .VOL_W  (VOL_W),
            .FREQ_W (FREQ_W)
         ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .tick    (tick_30k),
            .wr_c    (wr_c_s),
            .wr_f    (wr_f_s),
            .wr_v    (wr_v_s),
            .wdata   (data),
            .aud_bit (aud_bit[n]),
            .aud_vol (aud_vol[n*VOL_W +: VOL_W])
         );
      end
   endgenerate

`ifdef TIA_AUDIO_MIX_EN
   logic [MIX_W-1:0] sum_s;
   logic [MIX_W-1:0] mix_r;

   // Unsigned sum of all channel samples; width covers NUM_CH full-scale samples
   always_comb begin
      sum_s = {MIX_W{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         sum_s = sum_s + MIX_W'(aud_vol[i*VOL_W +: VOL_W]);
      end
   end

   // Mix register, one cycle behind aud_vol
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mix_r <= {MIX_W{1'b0}};
      end else begin
         mix_r <= sum_s;
      end
   end

   assign mix_out = mix_r;
`else
   assign mix_out = {MIX_W{1'b0}};
`endif

endmodule
